// File: rtl/task_map_pkg.sv
// Shared types for the task-graph link: edge-weight word, streamer FSM states,
// and the default graph size used by both streamer and mapper.
package task_map_pkg;

  localparam int unsigned TM_NUM_V = 4;
  localparam int unsigned TM_W     = 32;

  typedef logic [TM_W-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } stream_state_e;

endpackage

// File: rtl/task_graph_ram.sv
// Adjacency-matrix store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded graph survives a link reset.
module task_graph_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 32,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/task_graph_streamer.sv
// Transmit side of the task-graph link: serialises the adjacency matrix row-major,
// one word per valid/ready transfer, with launches spaced by GAP_CYCLES.
module task_graph_streamer
  import task_map_pkg::*;
#(
  parameter int unsigned NUM_V      = TM_NUM_V,
  parameter int unsigned W          = TM_W,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned RW        = (NUM_V > 1) ? $clog2(NUM_V) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [RW-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  task_array,
  output logic          task_valid,
  output logic          root_task,
  input  logic          task_ready
);

  localparam int unsigned DEPTH = NUM_V * NUM_V;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  stream_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  rdata;

  // Writes only land while idle so the matrix stays frozen for the whole stream.
  assign we    = wr_en && (state_q == IDLE) &&
                 (32'(wr_row) < NUM_V) && (32'(wr_col) < NUM_V);
  assign waddr = AW'(32'(wr_row) * NUM_V + 32'(wr_col));

  task_graph_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (task_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (GAP_CYCLES > 1) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state; the word is held because idx_q only moves on a transfer.
  always_comb begin
    task_valid = (state_q == SEND);
    task_array = task_valid ? rdata : '0;
    root_task  = task_valid && (idx_q == '0);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

endmodule
